// File: rtl/brg_cgra_sdr_link_endpoint_pkg.sv
// Shared constants and helpers for the CGRA-side SDR link endpoint.
//   LG_FIFO_DEPTH_DEF : default log2 of the RX FIFO depth (= far-end credits)
//   LG_DECIMATION_DEF : default log2 of credits represented by one token
//   depth_f / tokens_f: turn the log2 parameters into counts
//   credit_t          : credit counter type for the default depth
package brg_cgra_sdr_link_endpoint_pkg;

    localparam int unsigned LG_FIFO_DEPTH_DEF = 32'd3;
    localparam int unsigned LG_DECIMATION_DEF = 32'd0;

    // Number of RX FIFO entries, which is also the far-end credit count.
    function automatic int unsigned depth_f(input int unsigned lg_depth);
        return 32'd1 << lg_depth;
    endfunction

    // Number of credits one token pulse is worth.
    function automatic int unsigned tokens_f(input int unsigned lg_decimation);
        return 32'd1 << lg_decimation;
    endfunction

    // The counter must be able to hold the full depth, hence one extra bit.
    typedef logic [LG_FIFO_DEPTH_DEF:0] credit_t;

endpackage

// File: rtl/brg_cgra_sdr_link_endpoint_if.sv
// Bundle of link-side and core-side handshake signals of the endpoint.
// Signal suffixes are from the endpoint's point of view:
//   link_v_i/link_data_i   incoming link word      link_token_o  token to far end
//   link_v_o/link_data_o   outgoing link word      link_token_i  token from far end
//   core_v_o/core_data_o   RX word to core         core_yumi_i   core consumes RX head
//   core_v_i/core_data_i   TX word from core       core_ready_o  TX word accepted
// slave  : the endpoint.  master : whatever drives the link and the core side.
interface brg_cgra_sdr_link_endpoint_if #(
    parameter int unsigned width_p = 64
);
    logic               link_v_i;
    logic [width_p-1:0] link_data_i;
    logic               link_token_o;
    logic               link_v_o;
    logic [width_p-1:0] link_data_o;
    logic               link_token_i;
    logic               core_v_o;
    logic [width_p-1:0] core_data_o;
    logic               core_yumi_i;
    logic               core_v_i;
    logic [width_p-1:0] core_data_i;
    logic               core_ready_o;

    modport slave (
        input  link_v_i, link_data_i, link_token_i, core_yumi_i, core_v_i, core_data_i,
        output link_token_o, link_v_o, link_data_o, core_v_o, core_data_o, core_ready_o
    );

    modport master (
        output link_v_i, link_data_i, link_token_i, core_yumi_i, core_v_i, core_data_i,
        input  link_token_o, link_v_o, link_data_o, core_v_o, core_data_o, core_ready_o
    );
endinterface

// File: rtl/brg_cgra_sdr_link_endpoint_chk.sv
// Protocol and parameter checker for the link endpoint; carries no logic.
//   clk_i, reset_i     : clock and synchronous reset (checks held off in reset)
//   rx_overflow_i      : link word arrived with the RX FIFO full and no dequeue
//   yumi_empty_i       : core_yumi_i while no RX word was presented
//   credit_overflow_i  : returned credits would exceed the far-end depth
module brg_cgra_sdr_link_endpoint_chk #(
    parameter int unsigned lg_fifo_depth_p                 = 3,
    parameter int unsigned lg_credit_to_token_decimation_p = 0
) (
    input logic clk_i,
    input logic reset_i,
    input logic rx_overflow_i,
    input logic yumi_empty_i,
    input logic credit_overflow_i
);
    // Both counts are powers of two, so the token size divides the depth
    // exactly when its log2 is not larger.
    generate
        if ((lg_fifo_depth_p < 32'd1) ||
            (lg_credit_to_token_decimation_p > lg_fifo_depth_p)) begin : g_param_err
            $error("brg_cgra_sdr_link_endpoint: token credits must divide FIFO depth (depth >= 2)");
        end
    endgenerate

    a_rx_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !rx_overflow_i)
        else $error("brg_cgra_sdr_link_endpoint: RX FIFO overflow, link word dropped");

    a_yumi_empty: assert property (@(posedge clk_i) disable iff (reset_i) !yumi_empty_i)
        else $error("brg_cgra_sdr_link_endpoint: core_yumi_i with no RX word valid");

    a_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !credit_overflow_i)
        else $error("brg_cgra_sdr_link_endpoint: credit count exceeded far-end depth");
endmodule

// File: rtl/brg_cgra_sdr_link_endpoint_token_gen.sv
// Token generator: counts consumption events and emits a one-cycle registered
// token pulse every 2^lg_decimation_p events.
//   clk_i, reset_i : clock and synchronous active-high reset
//   v_i            : one consumption event this cycle
//   token_o        : token pulse, one cycle after the event that completes a group
module brg_cgra_sdr_link_endpoint_token_gen #(
    parameter int unsigned lg_decimation_p = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic v_i,
    output logic token_o
);
    logic token_d;
    logic token_q;

    generate
        if (lg_decimation_p == 32'd0) begin : g_direct
            // Every event is worth a whole token.
            always_comb begin
                token_d = v_i;
            end
        end else begin : g_count
            localparam int unsigned CNT_W = lg_decimation_p;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] cnt_q;

            // Token fires on the event that wraps the counter back to zero.
            always_comb begin
                cnt_d   = cnt_q;
                token_d = 1'b0;
                if (v_i) begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                    token_d = (cnt_q == {CNT_W{1'b1}});
                end else begin
                    cnt_d   = cnt_q;
                    token_d = 1'b0;
                end
            end

            // Decimation counter state.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Registered pulse output.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            token_q <= 1'b0;
        end else begin
            token_q <= token_d;
        end
    end

    assign token_o = token_q;
endmodule

// File: rtl/brg_cgra_sdr_link_endpoint.sv
// CGRA-side endpoint for one SDR link direction pair.
// RX half buffers incoming link words for the core and returns tokens as the
// core consumes them; TX half tracks far-end credits, launches core words on
// the link and recovers credits from incoming tokens.
// Ports:
//   clk_i, reset_i : core clock, synchronous active-high reset
//   bus_if         : link and core handshakes (brg_cgra_sdr_link_endpoint_if.slave)
// Optional build macro BRG_CGRA_SDR_LINK_STATS_EN adds:
//   stat_tx_cnt_o  : accepted TX words, mod 2^32
//   stat_rx_cnt_o  : enqueued RX words, mod 2^32
//   err_o          : sticky RX overflow / credit overflow flag
module brg_cgra_sdr_link_endpoint
    import brg_cgra_sdr_link_endpoint_pkg::*;
#(
    parameter int unsigned width_p                         = 64,
    parameter int unsigned lg_fifo_depth_p                 = LG_FIFO_DEPTH_DEF,
    parameter int unsigned lg_credit_to_token_decimation_p = LG_DECIMATION_DEF
) (
    input logic clk_i,
    input logic reset_i,
    brg_cgra_sdr_link_endpoint_if.slave bus_if
`ifdef BRG_CGRA_SDR_LINK_STATS_EN
    ,
    output logic [31:0] stat_tx_cnt_o,
    output logic [31:0] stat_rx_cnt_o,
    output logic        err_o
`endif
);
    localparam int unsigned DEPTH         = depth_f(lg_fifo_depth_p);
    localparam int unsigned TOKEN_CREDITS = tokens_f(lg_credit_to_token_decimation_p);
    localparam int unsigned PTR_W         = lg_fifo_depth_p;
    localparam int unsigned CNT_W         = lg_fifo_depth_p + 32'd1;
    // One more bit so credits + a token's worth cannot wrap before the compare.
    localparam int unsigned CALC_W        = lg_fifo_depth_p + 32'd2;

    // ---------------- RX FIFO ----------------
    logic [width_p-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_d, wptr_q;
    logic [PTR_W-1:0]   rptr_d, rptr_q;
    logic [CNT_W-1:0]   count_d, count_q;
    logic               full_s, empty_s, enq_s, deq_s;
    logic               rx_overflow_s, yumi_empty_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == '0);
    assign deq_s   = bus_if.core_yumi_i & ~empty_s;
    // A dequeue in the same cycle frees the slot, so a full FIFO still accepts.
    assign enq_s   = bus_if.link_v_i & (~full_s | deq_s);
    assign rx_overflow_s = bus_if.link_v_i & full_s & ~deq_s;
    assign yumi_empty_s  = bus_if.core_yumi_i & empty_s;

    // FIFO pointer and occupancy next state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq_s) begin
            wptr_d = wptr_q + PTR_W'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (deq_s) begin
            rptr_d = rptr_q + PTR_W'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (enq_s && !reset_i) begin
            mem_q[wptr_q] <= bus_if.link_data_i;
        end
    end

    assign bus_if.core_v_o    = ~empty_s;
    assign bus_if.core_data_o = mem_q[rptr_q];

    // Token return to the far end, one token per decimation group of dequeues.
    brg_cgra_sdr_link_endpoint_token_gen #(
        .lg_decimation_p (lg_credit_to_token_decimation_p)
    ) u_rx_token_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (deq_s),
        .token_o (bus_if.link_token_o)
    );

    // ---------------- TX path ----------------
    logic [CNT_W-1:0]   credits_d, credits_q;
    logic [CALC_W-1:0]  credit_sum_s;
    logic               credit_ovf_s;
    logic               ready_s, accept_s;
    logic               link_v_q;
    logic [width_p-1:0] link_data_q;

    // Ready is forced low during reset so nothing is accepted across it.
    assign ready_s  = (credits_q != '0) & ~reset_i;
    assign accept_s = bus_if.core_v_i & ready_s;

    // Credit update: a token and an accept in the same cycle both apply.
    always_comb begin
        credit_sum_s = {1'b0, credits_q};
        if (bus_if.link_token_i) begin
            credit_sum_s = credit_sum_s + CALC_W'(TOKEN_CREDITS);
        end else begin
            credit_sum_s = credit_sum_s;
        end
        if (accept_s) begin
            credit_sum_s = credit_sum_s - CALC_W'(1'b1);
        end else begin
            credit_sum_s = credit_sum_s;
        end
        credit_ovf_s = (credit_sum_s > CALC_W'(DEPTH));
        if (credit_ovf_s) begin
            credits_d = CNT_W'(DEPTH);
        end else begin
            credits_d = credit_sum_s[CNT_W-1:0];
        end
    end

    // Credit counter and registered outgoing link word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q   <= CNT_W'(DEPTH);
            link_v_q    <= 1'b0;
            link_data_q <= '0;
        end else begin
            credits_q <= credits_d;
            link_v_q  <= accept_s;
            if (accept_s) begin
                link_data_q <= bus_if.core_data_i;
            end
        end
    end

    assign bus_if.core_ready_o = ready_s;
    assign bus_if.link_v_o     = link_v_q;
    assign bus_if.link_data_o  = link_data_q;

`ifdef BRG_CGRA_SDR_LINK_STATS_EN
    logic [31:0] stat_tx_q;
    logic [31:0] stat_rx_q;
    logic        err_q;

    // Traffic counters and sticky protocol error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_tx_q <= 32'd0;
            stat_rx_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            stat_tx_q <= stat_tx_q + {31'd0, accept_s};
            stat_rx_q <= stat_rx_q + {31'd0, enq_s};
            err_q     <= err_q | rx_overflow_s | credit_ovf_s;
        end
    end

    assign stat_tx_cnt_o = stat_tx_q;
    assign stat_rx_cnt_o = stat_rx_q;
    assign err_o         = err_q;
`endif

    brg_cgra_sdr_link_endpoint_chk #(
        .lg_fifo_depth_p                 (lg_fifo_depth_p),
        .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
    ) u_chk (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .rx_overflow_i     (rx_overflow_s),
        .yumi_empty_i      (yumi_empty_s),
        .credit_overflow_i (credit_ovf_s)
    );
endmodule

// File: tb/tb_brg_cgra_sdr_link_endpoint.sv
// Bench for brg_cgra_sdr_link_endpoint. Two instances share one stimulus
// stream: dut0 with one credit per token, dut1 with four credits per token.
// The reference model keeps the RX contents as a queue and the credits as
// plain integers; expected TX words are queued when accepted and a negedge
// monitor pops and compares whatever the DUTs present.
module tb_brg_cgra_sdr_link_endpoint;
    localparam int W = 64;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, lv, yumi, cv, tok;
    logic [W-1:0] ld, cd;
    int           checks = 0;
    int           failures = 0;
    bit           mon_en = 1'b0;

    brg_cgra_sdr_link_endpoint_if #(.width_p(W)) if0 ();
    brg_cgra_sdr_link_endpoint_if #(.width_p(W)) if1 ();

    assign if0.link_v_i = lv;   assign if1.link_v_i = lv;
    assign if0.link_data_i = ld; assign if1.link_data_i = ld;
    assign if0.link_token_i = tok; assign if1.link_token_i = tok;
    assign if0.core_yumi_i = yumi; assign if1.core_yumi_i = yumi;
    assign if0.core_v_i = cv;   assign if1.core_v_i = cv;
    assign if0.core_data_i = cd; assign if1.core_data_i = cd;

`ifdef BRG_CGRA_SDR_LINK_STATS_EN
    logic [31:0] st_tx0, st_rx0, st_tx1, st_rx1;
    logic        err0, err1;
`endif

    brg_cgra_sdr_link_endpoint #(.width_p(W), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .bus_if(if0)
`ifdef BRG_CGRA_SDR_LINK_STATS_EN
        , .stat_tx_cnt_o(st_tx0), .stat_rx_cnt_o(st_rx0), .err_o(err0)
`endif
    );

    brg_cgra_sdr_link_endpoint #(.width_p(W), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(2)) dut1 (
        .clk_i(clk), .reset_i(rst), .bus_if(if1)
`ifdef BRG_CGRA_SDR_LINK_STATS_EN
        , .stat_tx_cnt_o(st_tx1), .stat_rx_cnt_o(st_rx1), .err_o(err1)
`endif
    );

    // ---------------- reference model ----------------
    logic [W-1:0] rxq[$];
    logic [W-1:0] txq0[$];
    logic [W-1:0] txq1[$];
    int           cred[2];
    int           ycnt[2];
    bit           exp_tok[2];
    int unsigned  m_tx[2];
    int unsigned  m_rx;

    function automatic int tk(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic void check(input string nm, input int k, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, got, exp);
        end
    endfunction

    // Advance one clock; the model consumes the inputs that were driven for it.
    task automatic step();
        bit acc[2];
        @(posedge clk);
        if (rst) begin
            rxq.delete(); txq0.delete(); txq1.delete();
            m_rx = 0;
            for (int k = 0; k < 2; k++) begin
                cred[k] = D; ycnt[k] = 0; exp_tok[k] = 1'b0; m_tx[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc[k]     = cv && (cred[k] > 0);
                exp_tok[k] = yumi && (((ycnt[k] + 1) % tk(k)) == 0);
                if (yumi) ycnt[k]++;
                cred[k] = cred[k] + (tok ? tk(k) : 0) - (acc[k] ? 1 : 0);
                if (acc[k]) m_tx[k]++;
            end
            if (acc[0]) txq0.push_back(cd);
            if (acc[1]) txq1.push_back(cd);
            if (yumi) void'(rxq.pop_front());
            if (lv) begin rxq.push_back(ld); m_rx++; end
        end
        #1;
    endtask

    // Random legal stimulus; percentages per input.
    task automatic rand_drive(input int p_lv, input int p_yumi, input int p_cv, input int p_tok);
        bit a0, a1;
        yumi = (rxq.size() != 0) && (int'($urandom_range(99)) < p_yumi);
        lv   = ((rxq.size() < D) || yumi) && (int'($urandom_range(99)) < p_lv);
        ld   = {$urandom, $urandom};
        cv   = int'($urandom_range(99)) < p_cv;
        cd   = {$urandom, $urandom};
        a0   = cv && (cred[0] > 0);
        a1   = cv && (cred[1] > 0);
        tok  = (cred[0] + 1 - int'(a0) <= D) && (cred[1] + 4 - int'(a1) <= D) &&
               (int'($urandom_range(99)) < p_tok);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("core_ready", 0, if0.core_ready_o, !rst && (cred[0] > 0));
            check("core_ready", 1, if1.core_ready_o, !rst && (cred[1] > 0));
            check("core_v", 0, if0.core_v_o, rxq.size() != 0);
            check("core_v", 1, if1.core_v_o, rxq.size() != 0);
            if (rxq.size() != 0) begin
                check("core_data", 0, if0.core_data_o, rxq[0]);
                check("core_data", 1, if1.core_data_o, rxq[0]);
            end
            check("link_v", 0, if0.link_v_o, txq0.size() != 0);
            check("link_v", 1, if1.link_v_o, txq1.size() != 0);
            if (if0.link_v_o === 1'b1 && txq0.size() != 0) check("link_data", 0, if0.link_data_o, txq0[0]);
            if (if1.link_v_o === 1'b1 && txq1.size() != 0) check("link_data", 1, if1.link_data_o, txq1[0]);
            txq0.delete();
            txq1.delete();
            check("link_token", 0, if0.link_token_o, exp_tok[0]);
            check("link_token", 1, if1.link_token_o, exp_tok[1]);
`ifdef BRG_CGRA_SDR_LINK_STATS_EN
            check("stat_tx", 0, st_tx0, m_tx[0]);
            check("stat_tx", 1, st_tx1, m_tx[1]);
            check("stat_rx", 0, st_rx0, m_rx);
            check("stat_rx", 1, st_rx1, m_rx);
            check("err", 0, err0, '0);
            check("err", 1, err1, '0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; lv = 1'b0; yumi = 1'b0; cv = 1'b0; tok = 1'b0; ld = '0; cd = '0;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_link_data", 0, if0.link_data_o, '0);
        check("reset_link_data", 1, if1.link_data_o, '0);

        // Exhaust all credits; offers beyond the eighth must stall.
        for (int i = 0; i < 12; i++) begin
            cv = 1'b1; cd = {$urandom, $urandom};
            step();
        end
        cv = 1'b0;

        // Token with no credits, then token plus accept together.
        tok = 1'b1;
        step();
        cv = 1'b1; cd = {$urandom, $urandom};
        step();
        tok = 1'b0; cv = 1'b0;

        // Back-to-back RX burst 0xA0..0xA7, consumed as soon as visible.
        for (int i = 0; i < 10; i++) begin
            yumi = (rxq.size() != 0);
            lv   = (i < 8);
            ld   = 64'(32'hA0 + i);
            step();
        end
        yumi = 1'b0; lv = 1'b0;

        // Random traffic, first RX-heavy then drain-heavy.
        for (int i = 0; i < 400; i++) begin
            rand_drive((i < 200) ? 70 : 30, (i < 200) ? 40 : 85, 50, 30);
            step();
        end

        // Drain RX, then queue three words and reset mid-operation.
        tok = 1'b0; cv = 1'b0; lv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            yumi = (rxq.size() != 0);
            step();
        end
        yumi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lv = 1'b1; ld = {$urandom, $urandom};
            cv = 1'b1; cd = {$urandom, $urandom};
            step();
        end
        lv = 1'b0; cv = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 150; i++) begin
            rand_drive(50, 60, 60, 35);
            step();
        end
        lv = 1'b0; yumi = 1'b0; cv = 1'b0; tok = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
